// File: rtl/mem_controller.sv
// Memory-access controller: arbitrates fetch and load/store ports onto one Memory port,
// with sub-word load extension, read-modify-write sub-word stores and misalignment rejection.
module mem_controller #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_instr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [1:0]  data_size,
    input  logic        data_unsigned,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  dbg_state
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // Handshake: req is held by the requester until its one-cycle ack; requests are only sampled in IDLE.
    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic        port_q, port_d;   // 1 = data port, 0 = fetch port
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;

    logic        data_win;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_we;
    logic        misaligned;
    logic [31:0] merged;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;

    always_comb begin
        data_win = data_req & (DATA_PRIORITY | ~fetch_req);
        sel_addr = data_win ? data_addr : fetch_addr;
        sel_size = data_win ? data_size : 2'b10;
        sel_we   = data_win & data_we;
        case (sel_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = sel_addr[0];
            default: misaligned = |sel_addr[1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        port_d  = port_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (data_win | fetch_req) begin
                    addr_d  = sel_addr;
                    size_d  = sel_size;
                    uns_d   = data_unsigned;
                    we_d    = sel_we;
                    port_d  = data_win;
                    wdata_d = data_wdata;
                    if (misaligned)                 state_d = S_ERR;
                    else if (sel_we && sel_size[1]) state_d = S_WR;
                    else                            state_d = S_RD;
                end
            end
            S_RD: begin
                buf_d   = mem_rdata;
                state_d = we_q ? S_WR : S_RESP;
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            port_q  <= 1'b0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            port_q  <= port_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
        end
    end

    // Store merge: untouched bytes come from the word read in RD.
    always_comb begin
        merged = buf_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end else begin
            merged = wdata_q;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = buf_q[7:0];
            2'd1:    lane_b = buf_q[15:8];
            2'd2:    lane_b = buf_q[23:16];
            default: lane_b = buf_q[31:24];
        endcase
        lane_h = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: load_val = buf_q;
        endcase
    end

    always_comb begin
        mem_read    = (state_q == S_RD);
        mem_write   = (state_q == S_WR);
        mem_address = (mem_read | mem_write) ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wdata   = mem_write ? merged : 32'd0;
        fetch_ack   = ((state_q == S_RESP) | (state_q == S_ERR)) & ~port_q;
        data_ack    = ((state_q == S_RESP) | (state_q == S_ERR)) & port_q;
        err         = (state_q == S_ERR);
        fetch_instr = ((state_q == S_RESP) & ~port_q) ? buf_q : 32'd0;
        data_rdata  = ((state_q == S_RESP) & port_q & ~we_q) ? load_val : 32'd0;
        dbg_state   = state_q;
    end
endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: word-array Memory model, scoreboard queue of expected read data.
module tb_mem_controller;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ack;
  logic [31:0] fetch_instr;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [1:0]  data_size = '0;
  logic        data_unsigned = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:511];

  mem_controller #(.DATA_PRIORITY(1'b1)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
    .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_unsigned(data_unsigned),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .err(err), .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  function automatic logic [8:0] midx(input logic [31:0] a);
    return {a[28], a[9:2]};
  endfunction

  assign mem_rdata = mem[midx(mem_address)];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] <= 32'd0;
    mem[midx(32'h10010008)] <= 32'd50;
    mem[midx(32'h00400000)] <= 32'h10010437;
  end

  always @(posedge clock) if (mem_write) mem[midx(mem_address)] <= mem_wdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_data(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
    @(negedge clock);
    data_we = we; data_size = size; data_unsigned = uns; data_addr = addr; data_wdata = wdata;
    data_req = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic drive_fetch(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clock);
    fetch_addr = addr;
    fetch_req = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic wait_ack(input bit is_fetch, output int cyc, output logic [31:0] rdata,
                          output logic e, output int rd_cyc, output int wr_cyc);
    cyc = -1; rd_cyc = -1; wr_cyc = -1; rdata = 'x; e = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock); @(negedge clock);
      if (mem_read && rd_cyc < 0) rd_cyc = c;
      if (mem_write && wr_cyc < 0) wr_cyc = c;
      if (is_fetch ? fetch_ack : data_ack) begin
        cyc = c; e = err;
        rdata = is_fetch ? fetch_instr : data_rdata;
        if (is_fetch) fetch_req = 1'b0; else data_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({fetch_ack, data_ack, err, mem_read, mem_write} !== 5'd0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_ctrl: acks/err/rd/wr=%b state=%0d, required 0", {fetch_ack, data_ack, err, mem_read, mem_write}, dbg_state);
    end
    checks++;
    if ({mem_address, mem_wdata, data_rdata, fetch_instr} !== 128'd0) begin
      errors++; $display("FAIL reset_buses: addr=%h wdata=%h rdata=%h instr=%h, required 0", mem_address, mem_wdata, data_rdata, fetch_instr);
    end
    reset = 1'b1;
  endtask

  task automatic test_word_store_load;
    int cyc, rc, wc; logic [31:0] rd, exp; logic e;
    drive_data(1'b1, 2'b10, 1'b0, 32'h10010000, 32'h8081F0F0, 32'd0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (cyc !== 2) begin errors++; $display("FAIL sw_ack_cycle: got %0d required 2", cyc); end
    checks++; if (wc !== 1 || rc !== -1) begin errors++; $display("FAIL sw_mem_strobes: rd %0d wr %0d required rd -1 wr 1", rc, wc); end
    checks++; if (rd !== exp || e !== 1'b0) begin errors++; $display("FAIL sw_rdata: got %h err %b required %h err 0", rd, e, exp); end
    @(negedge clock);
    checks++; if (data_ack !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL sw_ack_pulse: ack %b state %0d required 0/IDLE", data_ack, dbg_state); end
    checks++; if (mem[midx(32'h10010000)] !== 32'h8081F0F0) begin errors++; $display("FAIL sw_memory: got %h required 8081f0f0", mem[midx(32'h10010000)]); end

    drive_data(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0, 32'h8081F0F0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (cyc !== 2 || rc !== 1) begin errors++; $display("FAIL lw_timing: ack %0d rd %0d required 2/1", cyc, rc); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL lw_rdata: got %h required %h", rd, exp); end

    drive_data(1'b0, 2'b00, 1'b0, 32'h10010000, 32'h0, 32'hFFFFFFF0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (rd !== exp || cyc !== 2) begin errors++; $display("FAIL lb_rdata: got %h cyc %0d required %h cyc 2", rd, cyc, exp); end

    drive_data(1'b0, 2'b00, 1'b1, 32'h10010000, 32'h0, 32'h000000F0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (rd !== exp || cyc !== 2) begin errors++; $display("FAIL lbu_rdata: got %h cyc %0d required %h cyc 2", rd, cyc, exp); end
  endtask

  task automatic test_half_loads;
    int cyc, rc, wc; logic [31:0] rd, exp; logic e;
    drive_data(1'b0, 2'b01, 1'b0, 32'h10010002, 32'h0, 32'hFFFF8081);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (rd !== exp || cyc !== 2) begin errors++; $display("FAIL lh_rdata: got %h cyc %0d required %h cyc 2", rd, cyc, exp); end
    drive_data(1'b0, 2'b01, 1'b1, 32'h10010002, 32'h0, 32'h00008081);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (rd !== exp || cyc !== 2) begin errors++; $display("FAIL lhu_rdata: got %h cyc %0d required %h cyc 2", rd, cyc, exp); end
  endtask

  task automatic test_subword_store;
    int cyc, rc, wc; logic [31:0] rd, exp; logic e;
    drive_data(1'b1, 2'b00, 1'b0, 32'h10010001, 32'hDEADBE12, 32'd0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (cyc !== 3) begin errors++; $display("FAIL sb_ack_cycle: got %0d required 3", cyc); end
    checks++; if (rc !== 1 || wc !== 2) begin errors++; $display("FAIL sb_mem_strobes: rd %0d wr %0d required 1/2", rc, wc); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL sb_rdata: got %h required %h", rd, exp); end
    drive_data(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0, 32'h808112F0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL sb_readback: got %h required %h", rd, exp); end
  endtask

  task automatic test_misaligned;
    int cyc, rc, wc; logic [31:0] rd, exp; logic e;
    drive_data(1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0, 32'd0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (cyc !== 1 || e !== 1'b1) begin errors++; $display("FAIL mis_lw_ack: cyc %0d err %b required 1/1", cyc, e); end
    checks++; if (rd !== exp || rc !== -1 || wc !== -1) begin errors++; $display("FAIL mis_lw_side: rdata %h rd %0d wr %0d required %h/-1/-1", rd, rc, wc, exp); end
    drive_data(1'b1, 2'b01, 1'b0, 32'h10010003, 32'h5555, 32'd0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (cyc !== 1 || e !== 1'b1 || wc !== -1 || rc !== -1) begin errors++; $display("FAIL mis_sh: cyc %0d err %b rd %0d wr %0d required 1/1/-1/-1", cyc, e, rc, wc); end
    drive_fetch(32'h00400002, 32'd0);
    wait_ack(1'b1, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (cyc !== 1 || e !== 1'b1 || rd !== exp) begin errors++; $display("FAIL mis_fetch: cyc %0d err %b instr %h required 1/1/%h", cyc, e, rd, exp); end
    checks++; if (mem[midx(32'h10010000)] !== 32'h808112F0) begin errors++; $display("FAIL mis_memory: got %h required 808112f0", mem[midx(32'h10010000)]); end
  endtask

  task automatic test_contention;
    int dcyc = -1, fcyc = -1; logic [31:0] drd = 'x, frd = 'x, exp;
    @(negedge clock);
    data_we = 1'b0; data_size = 2'b10; data_unsigned = 1'b0; data_addr = 32'h10010008;
    fetch_addr = 32'h00400000;
    data_req = 1'b1; fetch_req = 1'b1;
    exp_q.push_back(32'd50);
    exp_q.push_back(32'h10010437);
    for (int c = 1; c <= 12 && (dcyc < 0 || fcyc < 0); c++) begin
      @(posedge clock); @(negedge clock);
      if (data_ack) begin dcyc = c; drd = data_rdata; data_req = 1'b0; end
      if (fetch_ack) begin fcyc = c; frd = fetch_instr; fetch_req = 1'b0; end
    end
    data_req = 1'b0; fetch_req = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (dcyc !== 2 || drd !== exp) begin errors++; $display("FAIL cont_data: cyc %0d rdata %h required 2/%h", dcyc, drd, exp); end
    exp = exp_q.pop_front();
    checks++; if (fcyc !== 5 || frd !== exp) begin errors++; $display("FAIL cont_fetch: cyc %0d instr %h required 5/%h", fcyc, frd, exp); end
  endtask

  task automatic test_reset_mid_write;
    int cyc, rc, wc; logic [31:0] rd, exp; logic e; bit bad_ack = 0;
    @(negedge clock);
    data_we = 1'b1; data_size = 2'b00; data_addr = 32'h10010000; data_wdata = 32'h000000AA;
    data_req = 1'b1;
    repeat (2) begin @(posedge clock); @(negedge clock); end
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_pre_wr: mem_write %b required 1", mem_write); end
    reset = 1'b0; data_req = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || data_ack !== 1'b0 || mem_address !== 32'd0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL rst_abort: wr %b ack %b addr %h state %0d required 0", mem_write, data_ack, mem_address, dbg_state);
    end
    repeat (2) begin @(negedge clock); if (data_ack || fetch_ack) bad_ack = 1; end
    reset = 1'b1;
    repeat (3) begin @(negedge clock); if (data_ack || fetch_ack || dbg_state != 3'd0) bad_ack = 1; end
    checks++; if (bad_ack) begin errors++; $display("FAIL rst_no_ack: ack or activity seen after abort, required none"); end
    checks++; if (mem[midx(32'h10010000)] !== 32'h808112F0) begin errors++; $display("FAIL rst_memory: got %h required 808112f0", mem[midx(32'h10010000)]); end
    drive_data(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0, 32'h808112F0);
    wait_ack(1'b0, cyc, rd, e, rc, wc); exp = exp_q.pop_front();
    checks++; if (rd !== exp || cyc !== 2) begin errors++; $display("FAIL rst_readback: got %h cyc %0d required %h cyc 2", rd, cyc, exp); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_half_loads();
    test_subword_store();
    test_misaligned();
    test_contention();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
